// File: rtl/data_store_buffer_pkg.sv
// data_store_buffer_pkg: sram-like size encodings, store entry layout and read FSM states
package data_store_buffer_pkg;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } store_entry_t;
  typedef enum logic {RD_IDLE, RD_WAIT} rd_state_t;
endpackage

// File: rtl/data_store_buffer_store_fifo.sv
// data_store_buffer_store_fifo: in-order store queue with wrap-bit pointers
module data_store_buffer_store_fifo
  import data_store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic         pop,
  input  store_entry_t din,
  output logic         full,
  output logic         empty,
  output store_entry_t head
);
  localparam int AW = $clog2(DEPTH);
  store_entry_t mem [DEPTH];
  logic [AW:0] wp, rp;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
  assign head  = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/data_store_buffer.sv
// data_store_buffer: posted-write buffer; stores acked at once and drained in order, loads wait for all stores
module data_store_buffer
  import data_store_buffer_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int MAX_WR_OUT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_wstrb,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic [31:0] cpu_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);
  localparam int CW = $clog2(MAX_WR_OUT + 1);
  localparam logic [CW-1:0] WR_MAX = CW'(MAX_WR_OUT);
  rd_state_t rd_state, rd_next;
  logic ready, ack_q, full, empty, idle, drain, load_ok, load_sel, push, pop, dec;
  logic [CW-1:0] wr_out;
  store_entry_t din, head;
  assign din = '{addr: cpu_addr, size: cpu_size, wstrb: cpu_wstrb, wdata: cpu_wdata};
  data_store_buffer_store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .resetn(resetn), .push(push), .pop(pop), .din(din),
    .full(full), .empty(empty), .head(head)
  );
  assign idle     = rd_state == RD_IDLE;
  assign drain    = ready && !empty && idle && (wr_out < WR_MAX);
  // loads only go out once nothing store-related is queued, in flight or still being acked
  assign load_ok  = ready && empty && (wr_out == '0) && idle && !ack_q;
  assign load_sel = load_ok && cpu_req && !cpu_wr;
  assign push     = ready && cpu_req && cpu_wr && !full && idle;
  assign pop      = drain && mem_addr_ok;
  assign dec      = idle && mem_data_ok && (wr_out != '0);
  assign cpu_addr_ok = push || (load_sel && mem_addr_ok);
  assign cpu_data_ok = ack_q || (!idle && mem_data_ok);
  assign cpu_rdata   = idle ? '0 : mem_rdata;
  assign mem_req   = drain || load_sel;
  assign mem_wr    = drain;
  assign mem_size  = drain ? head.size : load_sel ? cpu_size : SZ_BYTE;
  assign mem_addr  = drain ? head.addr : load_sel ? cpu_addr : '0;
  assign mem_wstrb = drain ? head.wstrb : '0;
  assign mem_wdata = drain ? head.wdata : '0;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      rd_state <= RD_IDLE;
      ready    <= 1'b0;
      ack_q    <= 1'b0;
      wr_out   <= '0;
    end else begin
      rd_state <= rd_next;
      ready    <= 1'b1;
      ack_q    <= push;
      wr_out   <= wr_out + CW'(pop) - CW'(dec);
    end
  always_comb begin
    rd_next = rd_state;
    rd_next = idle ? ((load_sel && mem_addr_ok) ? RD_WAIT : RD_IDLE)
                   : (mem_data_ok ? RD_IDLE : RD_WAIT);
  end
  // a store response with nothing in flight is a bridge protocol error
  assert property (@(posedge clk) disable iff (!resetn) !(idle && mem_data_ok && (wr_out == '0)));
endmodule

// File: tb/tb_data_store_buffer.sv
// tb_data_store_buffer: directed scoreboard bench with a latency-programmable bridge model
module tb_data_store_buffer;
  import data_store_buffer_pkg::*;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic cpu_req = 1'b0, cpu_wr = 1'b0;
  logic [1:0] cpu_size = '0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [3:0] cpu_wstrb = '0;
  logic cpu_addr_ok, cpu_data_ok, mem_req, mem_wr;
  logic [31:0] cpu_rdata, mem_addr, mem_wdata;
  logic [1:0] mem_size;
  logic [3:0] mem_wstrb;
  logic mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = '0;
  int checks = 0, failures = 0, cyc = 0, lat = 1, st_hs = 0, waited, hs0;
  typedef struct {int due; logic [31:0] data;} rsp_t;
  store_entry_t exp_mem[$];
  logic [31:0] exp_cpu[$];
  rsp_t pend[$];
  rsp_t rsp;
  store_entry_t e;
  logic [31:0] ram [logic [31:0]];

  data_store_buffer dut (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wstrb(cpu_wstrb), .cpu_wdata(cpu_wdata), .cpu_addr_ok(cpu_addr_ok),
    .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // bridge responses: one per cycle, in order, each no earlier than its due cycle
  always @(posedge clk) begin
    #1;
    cyc++;
    mem_data_ok = 1'b0;
    mem_rdata = '0;
    if (!resetn) pend.delete();
    else if (pend.size() > 0 && pend[0].due <= cyc) begin
      rsp = pend.pop_front();
      mem_data_ok = 1'b1;
      mem_rdata = rsp.data;
    end
  end

  always @(negedge clk) if (resetn) begin
    if (mem_req && mem_addr_ok) begin
      if (mem_wr) begin
        st_hs++;
        check("mem_store_expected", 32'(exp_mem.size() > 0), 32'd1);
        if (exp_mem.size() > 0) begin
          e = exp_mem.pop_front();
          check("mem_st_addr", mem_addr, e.addr);
          check("mem_st_size", 32'(mem_size), 32'(e.size));
          check("mem_st_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
          check("mem_st_wdata", mem_wdata, e.wdata);
        end
        ram[mem_addr] = mem_wdata;
        pend.push_back('{due: cyc + lat, data: 32'h0});
      end else begin
        check("load_no_store_outstanding", 32'(pend.size()), 32'd0);
        check("load_addr_pass", mem_addr, cpu_addr);
        check("load_size_pass", 32'(mem_size), 32'(cpu_size));
        pend.push_back('{due: cyc + 1, data: ram.exists(mem_addr) ? ram[mem_addr] : 32'hA5A5_0000});
      end
    end
    if (cpu_data_ok) begin
      check("cpu_data_ok_expected", 32'(exp_cpu.size() > 0), 32'd1);
      if (exp_cpu.size() > 0) check("cpu_rdata", cpu_rdata, exp_cpu.pop_front());
    end
  end

  task automatic cpu_op(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                        input logic [3:0] st, input logic [31:0] d, input logic [31:0] rd,
                        output int n);
    n = 0;
    cpu_req = 1'b1; cpu_wr = wr; cpu_size = sz; cpu_addr = a; cpu_wstrb = st; cpu_wdata = d;
    @(negedge clk);
    while (!cpu_addr_ok && n < 200) begin
      step();
      @(negedge clk);
      n++;
    end
    check("cpu_accept_in_bound", 32'(cpu_addr_ok), 32'd1);
    if (cpu_addr_ok) begin
      if (wr) exp_mem.push_back('{addr: a, size: sz, wstrb: st, wdata: d});
      exp_cpu.push_back(wr ? 32'h0 : rd);
    end
    step();
    cpu_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while ((exp_mem.size() > 0 || exp_cpu.size() > 0 || pend.size() > 0 || mem_req) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 300), 32'd1);
    step();
  endtask

  initial begin
    cpu_req = 1'b1; cpu_wr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_addr_ok", 32'(cpu_addr_ok), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_cpu_data_ok", 32'(cpu_data_ok), 32'd0);
    step();
    resetn = 1'b1;
    @(negedge clk);
    check("ready_gates_addr_ok", 32'(cpu_addr_ok), 32'd0);
    step();
    cpu_req = 1'b0;
    // single store
    mem_addr_ok = 1'b1; lat = 1;
    cpu_op(1'b1, SZ_WORD, 32'h1000, 4'hF, 32'hDEAD_BEEF, 32'h0, waited);
    check("single_store_same_cycle", 32'(waited), 32'd0);
    @(negedge clk);
    check("single_store_mem_req_next", 32'({mem_req, mem_wr}), 32'd3);
    wait_idle("single_store_idle");
    check("single_store_wr_out_zero", 32'(dut.wr_out), 32'd0);
    // byte store
    cpu_op(1'b1, SZ_BYTE, 32'h3003, 4'h8, 32'h1122_3344, 32'h0, waited);
    wait_idle("byte_store_idle");
    // full FIFO: four accepted, fifth held until a pop, then accepted the next cycle
    mem_addr_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cpu_op(1'b1, SZ_WORD, 32'(i * 4), 4'hF, 32'hA0 + 32'(i), 32'h0, waited);
      check("fill_accept", 32'(waited), 32'd0);
    end
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hA4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_hold", 32'(cpu_addr_ok), 32'd0);
      step();
    end
    mem_addr_ok = 1'b1;
    @(negedge clk);
    check("full_no_push_on_pop", 32'(cpu_addr_ok), 32'd0);
    step();
    cpu_op(1'b1, SZ_WORD, 32'h10, 4'hF, 32'hA4, 32'h0, waited);
    check("fifth_accept_after_pop", 32'(waited), 32'd0);
    wait_idle("full_idle");
    // load after store
    lat = 5;
    cpu_op(1'b1, SZ_WORD, 32'h2000, 4'hF, 32'h1234_5678, 32'h0, waited);
    cpu_op(1'b0, SZ_WORD, 32'h2000, 4'h0, 32'h0, 32'h1234_5678, waited);
    check("load_waits_for_store", 32'(waited > 0), 32'd1);
    wait_idle("load_after_store_idle");
    // outstanding store limit
    lat = 20; lat = lat;
    hs0 = st_hs;
    for (int i = 0; i < 6; i++) cpu_op(1'b1, SZ_WORD, 32'h4000 + 32'(i * 4), 4'hF, 32'hB0 + 32'(i), 32'h0, waited);
    repeat (6) step();
    @(negedge clk);
    check("max_wr_out_handshakes", 32'(st_hs - hs0), 32'd4);
    check("max_wr_out_req_low", 32'(mem_req), 32'd0);
    step();
    wait_idle("max_wr_out_idle");
    check("max_wr_out_counter_zero", 32'(dut.wr_out), 32'd0);
    // reset mid-operation
    lat = 1; mem_addr_ok = 1'b0;
    for (int i = 0; i < 3; i++) cpu_op(1'b1, SZ_WORD, 32'h5000 + 32'(i * 4), 4'hF, 32'hC0 + 32'(i), 32'h0, waited);
    resetn = 1'b0;
    exp_mem.delete();
    exp_cpu.delete();
    cpu_req = 1'b1; cpu_wr = 1'b1;
    #1;
    check("rst_mid_ctrl", 32'({cpu_addr_ok, cpu_data_ok, mem_req, mem_wr}), 32'd0);
    check("rst_mid_mem_addr", mem_addr, 32'd0);
    check("rst_mid_mem_wdata", mem_wdata, 32'd0);
    check("rst_mid_fields", 32'({mem_size, mem_wstrb}), 32'd0);
    check("rst_mid_cpu_rdata", cpu_rdata, 32'd0);
    step();
    step();
    resetn = 1'b1; cpu_req = 1'b0; mem_addr_ok = 1'b1;
    step();
    @(negedge clk);
    check("post_rst_mem_req", 32'(mem_req), 32'd0);
    check("post_rst_fifo_empty", 32'(dut.u_fifo.empty), 32'd1);
    step();
    cpu_op(1'b0, SZ_WORD, 32'h1000, 4'h0, 32'h0, 32'hDEAD_BEEF, waited);
    check("post_rst_load_immediate", 32'(waited), 32'd0);
    wait_idle("post_rst_idle");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
